fir_sample_memory: RTL

FIR_SAMPLE_MEMORY -- requirements
Module: fir_sample_memory

---
 rtl/fir_sample_memory_if.sv | 39 +++
 rtl/fir_sample_memory.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fir_sample_memory_if.sv
// FIR sample memory bus: engine dual-port access plus arbitrated host port.
// Master drives requests and engine control; slave is the memory block.
interface fir_sample_memory_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          eng_start;
  logic          eng_done;
  logic [AW-1:0] eng_addr_a;
  logic [DW-1:0] eng_rdata_a;
  logic [AW-1:0] eng_addr_b;
  logic [DW-1:0] eng_wdata_b;
  logic          eng_we_b;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          busy;
  logic          host_err;
  logic [7:0]    host_blocked;

  modport master (
    output eng_start, eng_done, eng_addr_a,
    output eng_addr_b, eng_wdata_b, eng_we_b,
    output host_req, host_we, host_addr, host_wdata,
    input  eng_rdata_a, host_ack, host_rdata,
    input  busy, host_err, host_blocked
  );

  modport slave (
    input  eng_start, eng_done, eng_addr_a,
    input  eng_addr_b, eng_wdata_b, eng_we_b,
    input  host_req, host_we, host_addr, host_wdata,
    output eng_rdata_a, host_ack, host_rdata,
    output busy, host_err, host_blocked
  );
endinterface

// File: rtl/fir_sample_memory.sv
// FIR sample memory: engine read/write ports, host access granted
// only while the engine is idle; write-first on same-edge collisions.
module fir_sample_memory #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input logic                clk,
  input logic                rst,
  fir_sample_memory_if.slave bus
);
  typedef enum logic [1:0] {
    H_IDLE,
    H_GRANT,
    H_RESP
  } hstate_e;

  localparam int Depth = 1 << AW;

  logic [DW-1:0] mem_q [Depth];

  hstate_e       state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q;
  logic          hwe_q;
  logic [AW-1:0] haddr_q;
  logic [DW-1:0] hwdata_q;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] hrdata_q, hrdata_d;
  logic          err_q, err_d;
  logic [7:0]    blk_q, blk_d;

  logic          grant;
  logic          stalled;
  logic          h_rd;
  logic          h_wr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] addr_a;

  always_comb begin
    stalled = bus.host_req & (busy_q | bus.eng_start);
    grant   = (state_q == H_IDLE) & bus.host_req
            & ~busy_q & ~bus.eng_start;
    h_rd    = (state_q == H_GRANT) & ~hwe_q;
    // Engine write always wins the single write port.
    h_wr    = (state_q == H_GRANT) & hwe_q & ~bus.eng_we_b;
    addr_a  = h_rd ? haddr_q : bus.eng_addr_a;
    wr_en   = bus.eng_we_b | h_wr;
    wr_addr = bus.eng_we_b ? bus.eng_addr_b : haddr_q;
    wr_data = bus.eng_we_b ? bus.eng_wdata_b : hwdata_q;
    if (wr_en && (wr_addr == addr_a)) begin
      rdata_a_d = wr_data;
    end else begin
      rdata_a_d = mem_q[addr_a];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      H_IDLE:  if (grant) state_d = H_GRANT;
      H_GRANT: state_d = H_RESP;
      H_RESP:  state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
  end

  always_comb begin
    busy_d   = busy_q;
    err_d    = err_q;
    blk_d    = blk_q;
    hrdata_d = hrdata_q;
    if (bus.eng_start) begin
      busy_d = 1'b1;
    end else if (bus.eng_done && !done_q) begin
      busy_d = 1'b0;
    end
    if (state_q == H_GRANT && hwe_q && bus.eng_we_b) begin
      err_d = 1'b1;
    end
    if (state_q == H_IDLE && stalled && blk_q != 8'hFF) begin
      blk_d = blk_q + 8'd1;
    end
    if (h_rd) begin
      hrdata_d = rdata_a_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= H_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hwe_q     <= 1'b0;
      haddr_q   <= '0;
      hwdata_q  <= '0;
      rdata_a_q <= '0;
      hrdata_q  <= '0;
      err_q     <= 1'b0;
      blk_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= bus.eng_done;
      rdata_a_q <= rdata_a_d;
      hrdata_q  <= hrdata_d;
      err_q     <= err_d;
      blk_q     <= blk_d;
      if (grant) begin
        hwe_q    <= bus.host_we;
        haddr_q  <= bus.host_addr;
        hwdata_q <= bus.host_wdata;
      end
    end
  end

  // Storage is deliberately not reset so samples survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign bus.eng_rdata_a  = rdata_a_q;
  assign bus.host_ack     = (state_q == H_RESP);
  assign bus.host_rdata   = hrdata_q;
  assign bus.busy         = busy_q;
  assign bus.host_err     = err_q;
  assign bus.host_blocked = blk_q;
endmodule
